// File: rtl/cc_operand_loader_if.sv
// Operand-loader bus: shared operand input, comparator hookup and status.
// The count signal exists only when CC_OPERANDLOADER_COUNT_EN is defined.
interface cc_operand_loader_if #(
    parameter int NUMBER_DATAWIDTH = 8
);
    logic [NUMBER_DATAWIDTH-1:0] CC_OPERANDLOADER_data_InBUS;
    logic                        CC_OPERANDLOADER_load_In;
    logic                        CC_OPERANDLOADER_clear_In;
    logic                        CC_OPERANDLOADER_lessthan_In;
    logic [NUMBER_DATAWIDTH-1:0] CC_OPERANDLOADER_dataA_OutBUS;
    logic [NUMBER_DATAWIDTH-1:0] CC_OPERANDLOADER_dataB_OutBUS;
    logic                        CC_OPERANDLOADER_valid_Out;
    logic                        CC_OPERANDLOADER_result_Out;
    logic                        CC_OPERANDLOADER_done_Out;
    logic [1:0]                  CC_OPERANDLOADER_state_OutBUS;
`ifdef CC_OPERANDLOADER_COUNT_EN
    logic [7:0]                  CC_OPERANDLOADER_count_OutBUS;
`endif

    modport slave (
`ifdef CC_OPERANDLOADER_COUNT_EN
        output CC_OPERANDLOADER_count_OutBUS,
`endif
        input  CC_OPERANDLOADER_data_InBUS,
        input  CC_OPERANDLOADER_load_In,
        input  CC_OPERANDLOADER_clear_In,
        input  CC_OPERANDLOADER_lessthan_In,
        output CC_OPERANDLOADER_dataA_OutBUS,
        output CC_OPERANDLOADER_dataB_OutBUS,
        output CC_OPERANDLOADER_valid_Out,
        output CC_OPERANDLOADER_result_Out,
        output CC_OPERANDLOADER_done_Out,
        output CC_OPERANDLOADER_state_OutBUS
    );

    modport master (
`ifdef CC_OPERANDLOADER_COUNT_EN
        input  CC_OPERANDLOADER_count_OutBUS,
`endif
        output CC_OPERANDLOADER_data_InBUS,
        output CC_OPERANDLOADER_load_In,
        output CC_OPERANDLOADER_clear_In,
        output CC_OPERANDLOADER_lessthan_In,
        input  CC_OPERANDLOADER_dataA_OutBUS,
        input  CC_OPERANDLOADER_dataB_OutBUS,
        input  CC_OPERANDLOADER_valid_Out,
        input  CC_OPERANDLOADER_result_Out,
        input  CC_OPERANDLOADER_done_Out,
        input  CC_OPERANDLOADER_state_OutBUS
    );
endinterface

// File: rtl/cc_operand_loader.sv
// Loads operands A then B for the less-than comparator and latches its result.
// Optional completed-compare counter: define CC_OPERANDLOADER_COUNT_EN.
module cc_operand_loader #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                  CC_OPERANDLOADER_CLOCK_50,
    input  logic                  CC_OPERANDLOADER_RESET_InLow,
    cc_operand_loader_if.slave    bus
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [NUMBER_DATAWIDTH-1:0] dataA_q, dataA_d;
    logic [NUMBER_DATAWIDTH-1:0] dataB_q, dataB_d;
    logic                        result_q, result_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;
    logic                        load_prev_q;
    logic                        load_edge;
`ifdef CC_OPERANDLOADER_COUNT_EN
    logic [7:0]                  count_q, count_d;
`endif

    assign load_edge = bus.CC_OPERANDLOADER_load_In & ~load_prev_q;

    always_ff @(posedge CC_OPERANDLOADER_CLOCK_50 or negedge CC_OPERANDLOADER_RESET_InLow) begin
        if (!CC_OPERANDLOADER_RESET_InLow) begin
            state_q     <= WAIT_A;
            dataA_q     <= '0;
            dataB_q     <= '0;
            result_q    <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            load_prev_q <= 1'b0;
`ifdef CC_OPERANDLOADER_COUNT_EN
            count_q     <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            dataA_q     <= dataA_d;
            dataB_q     <= dataB_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            load_prev_q <= bus.CC_OPERANDLOADER_load_In;
`ifdef CC_OPERANDLOADER_COUNT_EN
            count_q     <= count_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        dataA_d  = dataA_q;
        dataB_d  = dataB_q;
        result_d = result_q;
`ifdef CC_OPERANDLOADER_COUNT_EN
        count_d  = count_q;
`endif
        if (bus.CC_OPERANDLOADER_clear_In) begin
            state_d  = WAIT_A;
            dataA_d  = '0;
            dataB_d  = '0;
            result_d = 1'b0;
`ifdef CC_OPERANDLOADER_COUNT_EN
            count_d  = 8'd0;
`endif
        end else begin
            unique case (state_q)
                WAIT_A: begin
                    if (load_edge) begin
                        dataA_d = bus.CC_OPERANDLOADER_data_InBUS;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_edge) begin
                        dataB_d = bus.CC_OPERANDLOADER_data_InBUS;
                        state_d = SETTLE;
                    end
                end
                // Operands have been stable for a full cycle here.
                SETTLE: begin
                    result_d = bus.CC_OPERANDLOADER_lessthan_In;
                    state_d  = HOLD;
`ifdef CC_OPERANDLOADER_COUNT_EN
                    count_d  = count_q + 8'd1;
`endif
                end
                HOLD: begin
                    if (load_edge) begin
                        dataA_d  = bus.CC_OPERANDLOADER_data_InBUS;
                        dataB_d  = '0;
                        result_d = 1'b0;
                        state_d  = WAIT_B;
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end
        valid_d = (state_d == SETTLE) || (state_d == HOLD);
        done_d  = (state_d == HOLD);
    end

    assign bus.CC_OPERANDLOADER_dataA_OutBUS = dataA_q;
    assign bus.CC_OPERANDLOADER_dataB_OutBUS = dataB_q;
    assign bus.CC_OPERANDLOADER_valid_Out    = valid_q;
    assign bus.CC_OPERANDLOADER_result_Out   = result_q;
    assign bus.CC_OPERANDLOADER_done_Out     = done_q;
    assign bus.CC_OPERANDLOADER_state_OutBUS = state_q;
`ifdef CC_OPERANDLOADER_COUNT_EN
    assign bus.CC_OPERANDLOADER_count_OutBUS = count_q;
`endif

endmodule
